// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA bus type plus frame-probe state and result types
package vga_pkg;

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_bus;

  localparam int PIX_CNT_W = 21;
  localparam int SUM_W     = 16;

  typedef enum logic [1:0] {
    SYNC_WAIT,
    ACCUM,
    BLANK
  } probe_state_t;

  typedef struct packed {
    logic [2*SUM_W-1:0]   sum;
    logic [PIX_CNT_W-1:0] pix;
    logic [10:0]          lines;
    logic [11:0]          probe_rgb;
    logic                 probe_hit;
    logic                 err;
  } probe_result_t;

endpackage

// File: rtl/vga_probe_acc.sv
// rtl/vga_probe_acc.sv - per-frame checksum, counters, probe capture and hcount check
module vga_probe_acc
  import vga_pkg::*;
#(
  parameter int CHECK_HCOUNT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          pix_en,
  input  vga_bus        bus_in,
  input  logic          vblnk_q,
  input  logic          hblnk_q,
  input  logic [10:0]   hcount_q,
  input  logic [10:0]   probe_x,
  input  logic [10:0]   probe_y,
  output probe_result_t acc
);

  logic [SUM_W-1:0]     sum_a;
  logic [SUM_W-1:0]     sum_b;
  logic [SUM_W-1:0]     sum_a_nxt;
  logic [PIX_CNT_W-1:0] pix;
  logic [10:0]          lines;
  logic [11:0]          probe_rgb;
  logic                 probe_hit;
  logic                 err;
  logic                 active;
  logic                 prev_active;
  logic                 h_rise;
  logic                 probe_match;
  logic                 h_gap;
  logic                 unused_sync;

  assign active      = ~bus_in.vblnk & ~bus_in.hblnk;
  assign prev_active = ~vblnk_q & ~hblnk_q;
  assign h_rise      = bus_in.hblnk & ~hblnk_q;
  assign probe_match = (bus_in.vcount == probe_y) && (bus_in.hcount == probe_x);
  // The 11-bit compare makes hcount wrap from 2047 to 0 count as continuous.
  assign h_gap       = (CHECK_HCOUNT != 0) && prev_active &&
                       (bus_in.hcount != hcount_q + 11'd1);
  assign sum_a_nxt   = sum_a + SUM_W'(bus_in.rgb);
  assign unused_sync = bus_in.vsync ^ bus_in.hsync;

  // Accumulate one sample per clock; clear wins so a publish edge starts the next frame empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      sum_a     <= '0;
      sum_b     <= '0;
      pix       <= '0;
      lines     <= '0;
      probe_rgb <= '0;
      probe_hit <= 1'b0;
      err       <= 1'b0;
    end else if (pix_en) begin
      if (active) begin
        sum_a <= sum_a_nxt;
        sum_b <= sum_b + sum_a_nxt;
        if (pix != {PIX_CNT_W{1'b1}}) begin
          pix <= pix + PIX_CNT_W'(1);
        end
        if (probe_match) begin
          probe_rgb <= bus_in.rgb;
          probe_hit <= 1'b1;
        end
        if (h_gap) begin
          err <= 1'b1;
        end
      end
      if (h_rise && !bus_in.vblnk) begin
        lines <= lines + 11'd1;
      end
    end
  end

  assign acc = {sum_b, sum_a, pix, lines, probe_rgb, probe_hit, err};

endmodule

// File: rtl/vga_frame_probe.sv
// rtl/vga_frame_probe.sv - per-frame VGA stream signature with valid/ready result port
module vga_frame_probe
  import vga_pkg::*;
#(
  parameter int CHECK_HCOUNT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  vga_bus      bus_in,
  input  logic        en,
  input  logic [10:0] probe_x,
  input  logic [10:0] probe_y,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_sum,
  output logic [20:0] res_pix,
  output logic [10:0] res_lines,
  output logic [11:0] res_probe_rgb,
  output logic        res_probe_hit,
  output logic        res_err,
  output logic        overrun
);

  probe_state_t  state;
  probe_result_t acc;
  probe_result_t res_q;
  logic          vblnk_q;
  logic          hblnk_q;
  logic [10:0]   hcount_q;
  logic          v_fall;
  logic          v_rise;
  logic          publish;
  logic          pix_en;
  logic          clear;

  assign v_fall  = vblnk_q & ~bus_in.vblnk;
  assign v_rise  = ~vblnk_q & bus_in.vblnk;
  assign publish = en & (state == ACCUM) & v_rise;
  // The vblnk-fall sample that starts a frame is already frame data.
  assign pix_en  = en & ((state == ACCUM) | v_fall);
  assign clear   = ~en | publish;

  // Previous-cycle history for edge detection and the hcount continuity check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      hcount_q <= '0;
    end else begin
      vblnk_q  <= bus_in.vblnk;
      hblnk_q  <= bus_in.hblnk;
      hcount_q <= bus_in.hcount;
    end
  end

  // Frame tracking: only a frame entered at a vblnk fall is ever published.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC_WAIT;
    end else if (!en) begin
      state <= SYNC_WAIT;
    end else begin
      case (state)
        SYNC_WAIT: if (v_fall) state <= ACCUM;
        ACCUM:     if (v_rise) state <= BLANK;
        BLANK:     if (v_fall) state <= ACCUM;
        default:   state <= SYNC_WAIT;
      endcase
    end
  end

  vga_probe_acc #(
    .CHECK_HCOUNT(CHECK_HCOUNT)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .pix_en   (pix_en),
    .bus_in   (bus_in),
    .vblnk_q  (vblnk_q),
    .hblnk_q  (hblnk_q),
    .hcount_q (hcount_q),
    .probe_x  (probe_x),
    .probe_y  (probe_y),
    .acc      (acc)
  );

  // Result register: publish beats accept, and overwriting an unaccepted result is sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= '0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (publish) begin
      res_q     <= acc;
      res_valid <= 1'b1;
      if (res_valid && !res_ready) begin
        overrun <= 1'b1;
      end
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign res_sum       = res_q.sum;
  assign res_pix       = res_q.pix;
  assign res_lines     = res_q.lines;
  assign res_probe_rgb = res_q.probe_rgb;
  assign res_probe_hit = res_q.probe_hit;
  assign res_err       = res_q.err;

endmodule

// File: tb/tb_vga_frame_probe.sv
// tb/tb_vga_frame_probe.sv - scoreboard bench for vga_frame_probe
module tb_vga_frame_probe;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  vga_bus      bus;
  logic        en;
  logic [10:0] probe_x;
  logic [10:0] probe_y;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_sum;
  logic [20:0] res_pix;
  logic [10:0] res_lines;
  logic [11:0] res_probe_rgb;
  logic        res_probe_hit;
  logic        res_err;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  probe_result_t exp_q[$];
  probe_result_t mon_e;

  bit          synced;
  logic        m_prev_vb;
  logic        m_prev_hb;
  logic [11:0] rec_rgb[$];
  logic [10:0] rec_h[$];
  logic [10:0] rec_v[$];
  int          m_lines;
  logic [11:0] m_prg;
  bit          m_hit;

  always #5 clk = ~clk;

  vga_frame_probe #(.CHECK_HCOUNT(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus_in        (bus),
    .en            (en),
    .probe_x       (probe_x),
    .probe_y       (probe_y),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_sum       (res_sum),
    .res_pix       (res_pix),
    .res_lines     (res_lines),
    .res_probe_rgb (res_probe_rgb),
    .res_probe_hit (res_probe_hit),
    .res_err       (res_err),
    .overrun       (overrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void clear_rec();
    rec_rgb.delete();
    rec_h.delete();
    rec_v.delete();
    m_lines = 0;
    m_prg   = '0;
    m_hit   = 1'b0;
  endfunction

  // Reference: signature computed from the recorded list of active pixels of the frame.
  function automatic probe_result_t make_result();
    probe_result_t r;
    int a = 0;
    int b = 0;
    r = '0;
    foreach (rec_rgb[i]) begin
      a = (a + int'(rec_rgb[i])) % 65536;
      b = (b + a) % 65536;
    end
    r.sum       = {b[15:0], a[15:0]};
    r.pix       = (rec_rgb.size() > 2097151) ? 21'h1fffff : 21'(rec_rgb.size());
    r.lines     = 11'(m_lines);
    r.probe_rgb = m_prg;
    r.probe_hit = m_hit;
    for (int i = 1; i < rec_h.size(); i++) begin
      if (rec_v[i] == rec_v[i-1] && rec_h[i] != 11'(rec_h[i-1] + 11'd1)) r.err = 1'b1;
    end
    return r;
  endfunction

  function automatic void model_sample(input logic vb, input logic hb, input logic [10:0] v,
                                       input logic [10:0] h, input logic [11:0] rgb);
    if (!en) begin
      synced = 1'b0;
      clear_rec();
    end else begin
      if (!synced && m_prev_vb && !vb) begin
        synced = 1'b1;
        clear_rec();
      end
      if (synced) begin
        if (!m_prev_vb && vb) begin
          exp_q.push_back(make_result());
          clear_rec();
        end else begin
          if (!vb && !hb) begin
            rec_rgb.push_back(rgb);
            rec_h.push_back(h);
            rec_v.push_back(v);
            if (v == probe_y && h == probe_x) begin
              m_prg = rgb;
              m_hit = 1'b1;
            end
          end
          if (hb && !m_prev_hb && !vb) m_lines++;
        end
      end
    end
    m_prev_vb = vb;
    m_prev_hb = hb;
  endfunction

  function automatic void model_reset();
    synced    = 1'b0;
    m_prev_vb = 1'b0;
    m_prev_hb = 1'b0;
    clear_rec();
    exp_q.delete();
  endfunction

  task automatic drive(input logic vb, input logic hb, input logic [10:0] v,
                       input logic [10:0] h, input logic [11:0] rgb);
    bus.vblnk  = vb;
    bus.hblnk  = hb;
    bus.vcount = v;
    bus.hcount = h;
    bus.rgb    = rgb;
    @(posedge clk);
    #1;
    model_sample(vb, hb, v, h, rgb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 11'd0, 11'd0, 12'h000);
  endtask

  // mode 0: random rgb, 1: constant base, 2: base with 12'hfff at the probe coordinate.
  // abort 1: async reset mid-frame, 2: en dropped for the rest of the middle line.
  task automatic frame(input int w, input int h, input int mode, input logic [11:0] base,
                       input int skip_y, input int abort_kind, input bit ready_pulse);
    logic [11:0] rgb;
    logic [10:0] hx;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        hx = (y == skip_y && x >= 6) ? 11'(x + 1) : 11'(x);
        case (mode)
          0:       rgb = 12'($urandom);
          1:       rgb = base;
          default: rgb = (11'(x) == probe_x && 11'(y) == probe_y) ? 12'hfff : base;
        endcase
        drive(1'b0, 1'b0, 11'(y), hx, rgb);
        if (y == h / 2 && x == w / 2) begin
          if (abort_kind == 1) begin
            rst_n = 1'b0;
            #1;
            check("rst_async_valid", res_valid, 0);
            check("rst_async_sum", res_sum, 0);
            check("rst_async_overrun", overrun, 0);
            model_reset();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
          end else if (abort_kind == 2) begin
            en = 1'b0;
          end
        end
      end
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 11'(y), 11'(w + i), 12'h000);
      en = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (ready_pulse) res_ready = (i == 0);
      drive(1'b1, 1'b1, 11'(h), 11'(i), 12'h000);
    end
  endtask

  task automatic rand_frame();
    int w = $urandom_range(8, 40);
    int h = $urandom_range(3, 10);
    probe_x = 11'($urandom_range(0, w - 1));
    probe_y = 11'($urandom_range(0, h - 1));
    frame(w, h, 0, 12'h000, -1, 0, 1'b0);
  endtask

  // Monitor: a result is consumed on every cycle with res_valid & res_ready; overwritten results are dropped.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: result presented with sum %0h, none expected", res_sum);
      end else begin
        while (exp_q.size() > 1) void'(exp_q.pop_front());
        mon_e = exp_q.pop_front();
        check("sb_sum", res_sum, mon_e.sum);
        check("sb_pix", res_pix, mon_e.pix);
        check("sb_lines", res_lines, mon_e.lines);
        check("sb_probe_rgb", res_probe_rgb, mon_e.probe_rgb);
        check("sb_probe_hit", res_probe_hit, mon_e.probe_hit);
        check("sb_err", res_err, mon_e.err);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    res_ready  = 1'b1;
    probe_x    = '0;
    probe_y    = '0;
    bus        = '0;
    bus.vblnk  = 1'b1;
    bus.hblnk  = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", res_valid, 0);
    check("reset_sum", res_sum, 0);
    check("reset_pix", res_pix, 0);
    check("reset_lines", res_lines, 0);
    check("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    idle(4);

    // Small constant frame with known signature.
    res_ready = 1'b0;
    probe_x = 11'd100;
    probe_y = 11'd100;
    frame(4, 2, 1, 12'h001, -1, 0, 1'b0);
    check("t1_valid", res_valid, 1);
    check("t1_sum", res_sum, 32'h0024_0008);
    check("t1_pix", res_pix, 8);
    check("t1_lines", res_lines, 2);
    check("t1_err", res_err, 0);
    res_ready = 1'b1;
    idle(2);

    // Larger frame with a distinct pixel at the probe.
    probe_x = 11'd10;
    probe_y = 11'd1;
    frame(160, 120, 2, 12'h222, -1, 0, 1'b0);
    idle(2);

    // Random frames, one with the probe outside the frame.
    for (int k = 0; k < 3; k++) rand_frame();
    probe_x = 11'd2000;
    frame(12, 4, 0, 12'h000, -1, 0, 1'b0);

    // hcount skip 5 -> 7, then a clean frame.
    probe_x = 11'd3;
    probe_y = 11'd0;
    frame(20, 4, 0, 12'h000, 2, 0, 1'b0);
    frame(20, 4, 0, 12'h000, -1, 0, 1'b0);

    // Backpressure over three frames.
    res_ready = 1'b0;
    rand_frame();
    check("bp_f1_valid", res_valid, 1);
    check("bp_f1_overrun", overrun, 0);
    rand_frame();
    check("bp_f2_overrun", overrun, 1);
    rand_frame();
    res_ready = 1'b1;
    idle(1);
    res_ready = 1'b0;
    check("bp_accept_valid", res_valid, 0);
    check("bp_accept_overrun", overrun, 1);

    // Reset mid-frame with a result pending: nothing published for the partial frame.
    rand_frame();
    frame(16, 6, 0, 12'h000, -1, 1, 1'b0);
    check("rst_no_publish", res_valid, 0);
    res_ready = 1'b1;
    rand_frame();

    // Accept and publish on the same edge.
    res_ready = 1'b0;
    rand_frame();
    frame(14, 5, 0, 12'h000, -1, 0, 1'b1);
    check("same_edge_valid", res_valid, 1);
    check("same_edge_overrun", overrun, 0);
    res_ready = 1'b1;
    idle(2);

    // en dropped mid-frame keeps the pending result and skips the frame.
    res_ready = 1'b0;
    rand_frame();
    frame(16, 6, 0, 12'h000, -1, 2, 1'b0);
    check("en_pending_kept", res_valid, 1);
    check("en_no_overrun", overrun, 0);
    res_ready = 1'b1;
    idle(2);
    rand_frame();

    idle(4);
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
